debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  - Multi-channel debouncer for the keypad and button inputs. It is the parametrised successor of the single-input debouncer.
//  - Each of CHANNELS inputs gets a 2-FF synchroniser and an independent stability counter.
//  - All channels share one prescaler tick, which keeps the per-channel counters narrow.
//  - Outputs per channel: the debounced level plus one-cycle rise/fall strobes. The keypad scanner and the UI FSMs consume these directly.
// PARAMETERS
//  CHANNELS      16      number of independent inputs (>=1)
//  TICK_DIV      100000  clk cycles per sample tick (>=1; 1 = tick every cycle; 100000 = 1 ms at 100 MHz)
//  STABLE_TICKS  5       consecutive ticks an input must differ from clean before it is accepted (>=1)
//  RESET_LEVEL   0       CHANNELS-bit reset value of clean and of both sync stages
//  REPEAT_DELAY  500     ticks from rise to first repeat strobe (used only with DEBOUNCE_BANK_REPEAT_EN)
//  REPEAT_RATE   100     ticks between later repeat strobes (used only with DEBOUNCE_BANK_REPEAT_EN)
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous reset, active low
//  en            in   1         1 = debouncing runs; 0 = frozen and cleared (see BEHAVIOUR)
//  noisy         in   CHANNELS  raw asynchronous inputs
//  clean         out  CHANNELS  debounced levels
//  rise          out  CHANNELS  1-cycle strobe: clean went 0->1
//  fall          out  CHANNELS  1-cycle strobe: clean went 1->0
//  any_change    out  1         OR-reduction of (rise|fall), registered together with them
//  repeat_pulse  out  CHANNELS  1-cycle auto-repeat strobe; constant 0 without the macro
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - clean, sync0 and sync1 load RESET_LEVEL.
//    - rise, fall, any_change, repeat_pulse load 0.
//    - Prescaler, stability counters and repeat timers load 0.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps.
//    - tick=1 for exactly one cycle when the count equals TICK_DIV-1.
//    - Held at 0 while en=0.
//  - Per channel, every cycle: sync0<=noisy, then sync1<=sync0.
//  - Per channel stability counter:
//    - sync1==clean: counter <= 0 in any cycle, tick or not. A single glitch restarts the full count.
//    - sync1!=clean and tick: if counter==STABLE_TICKS-1, then clean<=sync1, counter<=0, and rise or fall=1 in the same cycle clean updates. Otherwise counter+1.
//  - Latency from a sync1 change to clean: between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles. Add 2 cycles for synchronisation.
//  - Strobes: rise, fall and any_change are high for exactly one cycle. Several channels may strobe in the same cycle; each has its own bit and any_change is 1.
//  - en=0:
//    - Counters and repeat timers clear; clean holds its value.
//    - rise, fall, repeat_pulse and any_change are forced 0.
//    - Sync stages keep sampling.
//    - On en 0->1 each channel restarts a full STABLE_TICKS count.
//  - Counter width: $clog2(STABLE_TICKS+1). Prescaler width: $clog2(TICK_DIV+1). No overflow is possible.
// CONFIGURATION
//  - DEBOUNCE_BANK_REPEAT_EN defined:
//    - Each channel has a tick counter that runs while clean=1 and en=1.
//    - repeat_pulse=1 on the tick at which REPEAT_DELAY ticks have elapsed since rise, then every REPEAT_RATE ticks after that.
//    - The timer clears on fall, on en=0 and on reset. No repeat_pulse is issued in the cycle of, or after, a fall.
//  - DEBOUNCE_BANK_REPEAT_EN undefined:
//    - No repeat logic is generated and repeat_pulse is tied to 0.
//    - The port list is identical in both builds.
// STRUCTURE
//  - debounce_pkg holds:
//    - localparam helper functions for counter widths (clog2 wrappers);
//    - default tick constants: TICK_1MS_100MHZ = 100000.
//  - Sub-module debounce_chan: one channel (sync, stability counter, edge strobes, optional repeat timer). It takes tick and en as inputs.
//  - debounce_bank holds the shared prescaler and a generate loop of CHANNELS x debounce_chan.
// TESTING (CHANNELS=4, TICK_DIV=4, STABLE_TICKS=3, RESET_LEVEL=0)
//  1. rst_n=0 with noisy=4'hF: clean=0 and all strobes 0. After release with noisy held at F, rise=4'hF for one cycle within 15 cycles and clean=F.
//  2. Bounce: noisy[0] toggles every 3 cycles for 30 cycles, then stays 1. No rise[0] during the bounce; exactly one rise[0] 9-14 cycles after settling.
//  3. Simultaneous: noisy[1] 0->1 and noisy[2] 1->0 in the same cycle. rise=4'b0010 and fall=4'b0100 in the same cycle, with any_change=1 for one cycle.
//  4. Glitch: a 2-cycle 0 pulse on a stable-high noisy[3] gives no fall[3] and clean[3] stays 1.
//  5. en=0 mid-count, then en=1: clean does not change while disabled. After re-enable a full 3-tick count is needed before the strobe.
//  6. With DEBOUNCE_BANK_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, ch0 held: repeat_pulse[0] comes 5 ticks (20 cycles) after rise[0], then every 8 cycles. It stops at fall[0]. Without the macro it is always 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the debounce bank and its channels.
// Pure definitions: no logic, no latency, no flow control.
package debounce_pkg;

  localparam int TICK_1MS_100MHZ = 100000;

  // Bits needed to hold any value 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF sync, tick-based stability counter, edge strobes, optional auto-repeat
// (DEBOUNCE_BANK_REPEAT_EN). Clean follows sync1 after STABLE_TICKS ticks; no backpressure, strobes are 1 cycle.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = 5,
  parameter logic RST_VAL      = 1'b0,
  parameter int   REPEAT_DELAY = 500,
  parameter int   REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic repeat_pulse,
  output logic change_nxt
);

  localparam int CW = cnt_w(STABLE_TICKS);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;
  logic          rise_nxt;
  logic          fall_nxt;

  assign differ     = (sync1 != clean);
  assign accept     = en & tick & differ & (cnt == CW'(STABLE_TICKS - 1));
  assign rise_nxt   = accept & sync1;
  assign fall_nxt   = accept & ~sync1;
  assign change_nxt = rise_nxt | fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= RST_VAL;
      sync1 <= RST_VAL;
      clean <= RST_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync0 <= noisy;
      sync1 <= sync0;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      // Any cycle where the input agrees with clean restarts the full count.
      if (!en || !differ) begin
        cnt <= '0;
      end else if (accept) begin
        clean <= sync1;
        cnt   <= '0;
      end else if (tick) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_RATE));

  logic [RW-1:0] rcnt;
  logic          rfirst_done;
  logic [RW-1:0] rtarget;
  logic          rfire;

  assign rtarget = rfirst_done ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
  // A falling edge in the same cycle wins over a due repeat.
  assign rfire   = en & tick & clean & ~fall_nxt & (rcnt == rtarget);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt         <= '0;
      rfirst_done  <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rfire;
      if (!en || !clean || fall_nxt) begin
        rcnt        <= '0;
        rfirst_done <= 1'b0;
      end else if (rfire) begin
        rcnt        <= '0;
        rfirst_done <= 1'b1;
      end else if (tick) begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ((REPEAT_DELAY + REPEAT_RATE) != 0);
  assign repeat_pulse      = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// CHANNELS-wide debouncer sharing one prescaler tick; auto-repeat built only with DEBOUNCE_BANK_REPEAT_EN.
// Latency (STABLE_TICKS-1)*TICK_DIV+3 .. STABLE_TICKS*TICK_DIV+2 cycles; no backpressure, strobes are 1 cycle.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS     = 16,
  parameter int                  TICK_DIV     = TICK_1MS_100MHZ,
  parameter int                  STABLE_TICKS = 5,
  parameter logic [CHANNELS-1:0] RESET_LEVEL  = '0,
  parameter int                  REPEAT_DELAY = 500,
  parameter int                  REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int PW = cnt_w(TICK_DIV);

  logic [PW-1:0]       pcnt;
  logic                tick;
  logic [CHANNELS-1:0] change_nxt;

  assign tick = en & (pcnt == PW'(TICK_DIV - 1));

  // Held at zero while disabled so every re-enable starts a whole tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |change_nxt;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .RST_VAL      (RESET_LEVEL[i]),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .tick         (tick),
      .noisy        (noisy[i]),
      .clean        (clean[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .repeat_pulse (repeat_pulse[i]),
      .change_nxt   (change_nxt[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with 4 channels, TICK_DIV=4, STABLE_TICKS=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] noisy;
  logic [3:0] clean;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_change;
  logic [3:0] repeat_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS     (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .RESET_LEVEL  (4'h0),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .noisy        (noisy),
    .clean        (clean),
    .rise         (rise),
    .fall         (fall),
    .any_change   (any_change),
    .repeat_pulse (repeat_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int cnt;
    int bad;

    // 1. reset holds everything at RESET_LEVEL / 0 even with inputs high
    rst_n = 1'b0;
    en    = 1'b1;
    noisy = 4'hF;
    step(3);
    check("rst_clean", clean, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_any", any_change, 1'b0);
    check("rst_repeat", repeat_pulse, 4'h0);

    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (rise != 4'h0) begin
        n = i;
        break;
      end
    end
    check("t1_rise_all", rise, 4'hF);
    check("t1_within_15", (n >= 1 && n <= 15), 1'b1);
    check("t1_clean", clean, 4'hF);
    check("t1_any", any_change, 1'b1);
    step(1);
    check("t1_rise_one_cycle", rise, 4'h0);
    check("t1_any_one_cycle", any_change, 1'b0);

    // settle to ch0=0 ch1=0 ch2=1 ch3=1
    noisy = 4'b1100;
    step(30);
    check("setup_clean", clean, 4'b1100);

    // 2. bounce on ch0: 3-cycle segments never survive 3 ticks
    cnt = 0;
    for (int s = 0; s < 10; s++) begin
      noisy[0] = (s % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step(1);
        if (rise[0]) cnt++;
      end
    end
    check("t2_no_rise_in_bounce", cnt, 0);
    noisy[0] = 1'b1;
    n   = 0;
    cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (rise[0]) begin
        cnt++;
        if (n == 0) n = i;
      end
    end
    check("t2_single_rise", cnt, 1);
    check("t2_latency_9_14", (n >= 9 && n <= 14), 1'b1);
    check("t2_clean", clean, 4'b1101);

    // 3. simultaneous rise on ch1 and fall on ch2
    noisy = 4'b1011;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (any_change) break;
    end
    check("t3_rise", rise, 4'b0010);
    check("t3_fall", fall, 4'b0100);
    check("t3_any", any_change, 1'b1);
    step(1);
    check("t3_any_one_cycle", any_change, 1'b0);
    check("t3_strobes_clear", {rise, fall}, 8'h00);
    check("t3_clean", clean, 4'b1011);

    // 4. 2-cycle low glitch on stable-high ch3
    noisy[3] = 1'b0;
    step(2);
    noisy[3] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (fall[3] || !clean[3]) cnt++;
    end
    check("t4_glitch_ignored", cnt, 0);
    check("t4_clean", clean, 4'b1011);

    // 5. disable mid-count on a ch0 fall, then re-enable
    noisy[0] = 1'b0;
    step(7);
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (clean !== 4'b1011 || rise != 4'h0 || fall != 4'h0 || any_change || repeat_pulse != 4'h0) bad++;
    end
    check("t5_frozen_while_off", bad, 0);
    en = 1'b1;
    n  = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (fall[0]) begin
        n = i;
        break;
      end
    end
    // prescaler and counter restart from zero: third tick lands 12 cycles later
    check("t5_full_recount", n, 12);
    check("t5_clean", clean, 4'b1010);

    // 6. hold ch0 high and watch auto-repeat
    noisy[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (rise[0]) break;
    end
    check("t6_rise", rise[0], 1'b1);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (repeat_pulse[0]) begin
        n = i;
        break;
      end
    end
    check("t6_first_repeat_20", n, 20);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 1; i <= 12; i++) begin
        step(1);
        if (repeat_pulse[0]) begin
          n = i;
          break;
        end
      end
      check("t6_repeat_every_8", n, 8);
    end
    noisy[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (fall[0]) break;
    end
    check("t6_fall", fall[0], 1'b1);
    cnt = repeat_pulse[0] ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (repeat_pulse[0]) cnt++;
    end
    check("t6_no_repeat_after_fall", cnt, 0);
`else
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (repeat_pulse != 4'h0) cnt++;
    end
    check("t6_repeat_tied_low", cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
